// File: rtl/gerenciador_es_fila.sv
// Switch/display I/O manager for the DE2-115 board.
// Debounces the switch bank into a capture register and queues processor
// writes to the 7-segment display, holding each shown value for a minimum
// number of cycles so that back-to-back writes remain readable.
module gerenciador_es_fila #(
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       SW_W    = 16,        // SW_W <= DATA_W
  parameter int unsigned       DEPTH   = 4,         // power of 2, >= 2
  parameter int unsigned       HOLD    = 50000000,
  parameter int unsigned       DEB     = 1000000,   // >= 1
  parameter logic [DATA_W-1:0] RST_VAL = DATA_W'(170)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] dado,
  input  logic              RegToDisp,
  input  logic              SwToReg,
  input  logic [SW_W-1:0]   switches,
  output logic [DATA_W-1:0] stdout,
  output logic [DATA_W-1:0] dado_sw32,
  output logic              sw_new,
  output logic              disp_full,
  output logic              disp_ovf
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned HCNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int unsigned DCNT_W = (DEB > 1) ? $clog2(DEB) : 1;

  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD - 1);
  localparam logic [DCNT_W-1:0] DEB_LAST  = DCNT_W'(DEB - 1);

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_HOLD
  } disp_state_e;

  // ---------------------------------------------------------------------
  // Switch path state
  // ---------------------------------------------------------------------
  logic [SW_W-1:0]   sync1_q, sync1_d;
  logic [SW_W-1:0]   sync2_q, sync2_d;
  logic [SW_W-1:0]   cand_q, cand_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [SW_W-1:0]   deb_q, deb_d;
  logic              sw_new_q, sw_new_d;
  logic [DATA_W-1:0] dado_sw32_q, dado_sw32_d;

  // ---------------------------------------------------------------------
  // Display FIFO and hold state
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  disp_state_e       state_q, state_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [DATA_W-1:0] stdout_q, stdout_d;

  logic fifo_full;
  logic push_ok;
  logic pop;

  assign fifo_full = (count_q == DEPTH_C);
  assign push_ok   = RegToDisp && !fifo_full;

  // Synchroniser, debounce and capture next-state
  always_comb begin
    sync1_d     = switches;
    sync2_d     = sync1_q;
    cand_d      = cand_q;
    dcnt_d      = dcnt_q;
    deb_d       = deb_q;
    sw_new_d    = sw_new_q;
    dado_sw32_d = dado_sw32_q;

    // Capture uses the registered deb, so a same-cycle update is not seen
    // here; the clear is written first so a simultaneous set wins below.
    if (SwToReg) begin
      dado_sw32_d = DATA_W'(deb_q);
      sw_new_d    = 1'b0;
    end

    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      dcnt_d = '0;
    end else if ((dcnt_q == DEB_LAST) && (cand_q != deb_q)) begin
      deb_d    = cand_q;
      sw_new_d = 1'b1;
    end else if (dcnt_q < DEB_LAST) begin
      dcnt_d = dcnt_q + DCNT_W'(1);
    end
  end

  // Switch path registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      cand_q      <= '0;
      dcnt_q      <= '0;
      deb_q       <= '0;
      sw_new_q    <= 1'b0;
      dado_sw32_q <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cand_q      <= cand_d;
      dcnt_q      <= dcnt_d;
      deb_q       <= deb_d;
      sw_new_q    <= sw_new_d;
      dado_sw32_q <= dado_sw32_d;
    end
  end

  // Display state machine: pop the head into stdout and enforce the hold time
  always_comb begin
    pop      = 1'b0;
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    stdout_d = stdout_q;

    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop      = 1'b1;
          stdout_d = mem_q[rd_ptr_q];
          hcnt_d   = '0;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (hcnt_q == HOLD_LAST) begin
          if (count_q != '0) begin
            pop      = 1'b1;
            stdout_d = mem_q[rd_ptr_q];
            hcnt_d   = '0;
          end else begin
            hcnt_d  = '0;
            state_d = ST_IDLE;
          end
        end else begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end
      end
      default: begin
        hcnt_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO storage, pointers, occupancy and sticky overflow
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
    ovf_d    = ovf_q | (RegToDisp && fifo_full);

    if (push_ok) begin
      mem_d[wr_ptr_q] = dado;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO data array; contents are don't-care while the count says empty
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // FIFO control and display registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= ST_IDLE;
      hcnt_q   <= '0;
      stdout_q <= RST_VAL;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      stdout_q <= stdout_d;
    end
  end

  assign stdout    = stdout_q;
  assign dado_sw32 = dado_sw32_q;
  assign sw_new    = sw_new_q;
  assign disp_full = fifo_full;
  assign disp_ovf  = ovf_q;

endmodule
